// File: rtl/vga_arb_pkg.sv
// ============================================================================
//  Module      : vga_arb_pkg
//  Description : Shared definitions for the VGA pixel-write arbiter: the
//                arbiter state encoding, default clear-sweep geometry and
//                the adapter pixel field widths.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package vga_arb_pkg;

    // Arbiter state encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_CLEAR = 2'd2
    } arb_state_t;

    // Default clear-sweep geometry (160x120 adapter resolution)
    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;

    // Adapter pixel field widths
    localparam int X_W = 8;
    localparam int Y_W = 7;
    localparam int C_W = 3;

endpackage

`default_nettype wire

// File: rtl/vga_rr_pick.sv
// ============================================================================
//  Module      : vga_rr_pick
//  Description : Combinational round-robin picker. Selects the first active
//                requester at or after the rotation pointer, wrapping around.
//  Ports       : i_req    - per-client request vector
//                i_rr_ptr - index of the highest-priority client this round
//                o_pick   - one-hot selected client
//                o_valid  - at least one request is active
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module vga_rr_pick
    import vga_arb_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PTR_W-1:0] i_rr_ptr,
    output logic [N_REQ-1:0] o_pick,
    output logic             o_valid
);

    // Walk the offsets from the pointer outward; the inner loop matches the
    // wrapped position against a constant index so no variable bit-select
    // is needed.
    always_comb begin
        o_pick  = '0;
        o_valid = 1'b0;
        for (int off = 0; off < N_REQ; off++) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (!o_valid && i_req[j] &&
                    (j == ((int'(i_rr_ptr) + off) % N_REQ))) begin
                    o_pick[j] = 1'b1;
                    o_valid   = 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/vga_write_arbiter.sv
// ============================================================================
//  Module      : vga_write_arbiter
//  Description : Shares the single VGA adapter pixel-write port among N_REQ
//                drawing clients. Round-robin grants held for a whole burst,
//                with a built-in full-screen clear engine that runs after
//                reset and on request, taking priority at burst boundaries.
//  Ports       : clk, reset (sync, active-low)
//                i_req/i_plot_in/i_last     - per-client handshake
//                i_x_in/i_y_in/i_colour_in  - packed per-client pixel fields
//                i_clear_req                - one-cycle clear request pulse
//                o_gnt                      - registered one-hot grant
//                o_clear_busy               - high while sweep pixels emitted
//                o_vga_x/y/colour/plot      - adapter write port
//                o_timeout_err              - only with ARB_TIMEOUT_EN
//  Options     : define ARB_TIMEOUT_EN to add a MAX_BURST grant watchdog.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module vga_write_arbiter
    import vga_arb_pkg::*;
#(
    parameter int N_REQ     = 3,
    parameter int SCREEN_W  = SCREEN_W_DEF,
    parameter int SCREEN_H  = SCREEN_H_DEF,
    parameter int MAX_BURST = 512
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       i_req,
    input  logic [N_REQ-1:0]       i_plot_in,
    input  logic [N_REQ-1:0]       i_last,
    input  logic [X_W*N_REQ-1:0]   i_x_in,
    input  logic [Y_W*N_REQ-1:0]   i_y_in,
    input  logic [C_W*N_REQ-1:0]   i_colour_in,
    input  logic                   i_clear_req,
    output logic [N_REQ-1:0]       o_gnt,
    output logic                   o_clear_busy,
    output logic [X_W-1:0]         o_vga_x,
    output logic [Y_W-1:0]         o_vga_y,
    output logic [C_W-1:0]         o_vga_colour,
    output logic                   o_vga_plot
`ifdef ARB_TIMEOUT_EN
    ,
    output logic                   o_timeout_err
`endif
);

    localparam int PTR_W = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || MAX_BURST < 1) begin : g_bad_cfg
        $error("vga_write_arbiter: unsupported N_REQ or MAX_BURST");
    end

    arb_state_t        r_state, w_state_n;
    logic [PTR_W-1:0]  r_rr_ptr, w_rr_ptr_n;
    logic [PTR_W-1:0]  r_idx, w_idx_n, w_pick_idx;
    logic              r_clear_pending, w_clear_pending_n;
    logic [N_REQ-1:0]  r_gnt, w_gnt_n, w_pick;
    logic              w_pick_valid;
    logic [X_W-1:0]    r_cx, w_cx_n, r_x, w_x_n, w_sel_x;
    logic [Y_W-1:0]    r_cy, w_cy_n, r_y, w_y_n, w_sel_y;
    logic [C_W-1:0]    r_col, w_col_n, w_sel_col;
    logic              r_plot, w_plot_n, r_busy, w_busy_n;
    logic              w_eob, w_timeout;

    vga_rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .i_req    (i_req),
        .i_rr_ptr (r_rr_ptr),
        .o_pick   (w_pick),
        .o_valid  (w_pick_valid)
    );

    // One-hot pick to index, and AND-OR mux of the granted client's fields
    // keyed directly on the registered one-hot grant.
    always_comb begin
        w_pick_idx = '0;
        w_sel_x    = '0;
        w_sel_y    = '0;
        w_sel_col  = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (w_pick[j]) w_pick_idx = PTR_W'(j);
            w_sel_x   = w_sel_x   | (i_x_in[j*X_W +: X_W]      & {X_W{r_gnt[j]}});
            w_sel_y   = w_sel_y   | (i_y_in[j*Y_W +: Y_W]      & {Y_W{r_gnt[j]}});
            w_sel_col = w_sel_col | (i_colour_in[j*C_W +: C_W] & {C_W{r_gnt[j]}});
        end
    end

    // Burst ends on a plotted last pixel or when the owner drops its request
    assign w_eob = (|(i_plot_in & i_last & r_gnt)) | ~(|(i_req & r_gnt));

`ifdef ARB_TIMEOUT_EN
    localparam int BCNT_W = $clog2(MAX_BURST + 1);
    logic [BCNT_W-1:0] r_bcnt;
    logic              r_timeout;

    assign w_timeout = (r_state == ST_GRANT) && !w_eob &&
                       (r_bcnt == BCNT_W'(MAX_BURST - 1));

    // Counter idles at zero outside GRANT so each grant starts fresh
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_bcnt    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_timeout;
            if (r_state == ST_GRANT) r_bcnt <= r_bcnt + 1'b1;
            else                     r_bcnt <= '0;
        end
    end

    assign o_timeout_err = r_timeout;
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_n         = r_state;
        w_rr_ptr_n        = r_rr_ptr;
        w_idx_n           = r_idx;
        w_clear_pending_n = r_clear_pending | i_clear_req;
        w_gnt_n           = r_gnt;
        w_cx_n            = r_cx;
        w_cy_n            = r_cy;
        w_x_n             = r_x;
        w_y_n             = r_y;
        w_col_n           = r_col;
        w_plot_n          = 1'b0;
        w_busy_n          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_clear_pending) begin
                    // A clear_req arriving on this same cycle is absorbed
                    // into the sweep about to start.
                    w_state_n         = ST_CLEAR;
                    w_clear_pending_n = 1'b0;
                end else if (w_pick_valid) begin
                    w_gnt_n   = w_pick;
                    w_idx_n   = w_pick_idx;
                    w_state_n = ST_GRANT;
                end
            end
            ST_GRANT: begin
                w_x_n    = w_sel_x;
                w_y_n    = w_sel_y;
                w_col_n  = w_sel_col;
                w_plot_n = |(i_plot_in & r_gnt);
                if (w_eob || w_timeout) begin
                    w_gnt_n    = '0;
                    w_rr_ptr_n = (r_idx == PTR_W'(N_REQ - 1)) ? '0 : r_idx + 1'b1;
                    w_state_n  = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                w_x_n    = r_cx;
                w_y_n    = r_cy;
                w_col_n  = '0;
                w_plot_n = 1'b1;
                w_busy_n = 1'b1;
                if (r_cx == X_W'(SCREEN_W - 1)) begin
                    w_cx_n = '0;
                    if (r_cy == Y_W'(SCREEN_H - 1)) begin
                        w_cy_n            = '0;
                        w_state_n         = ST_IDLE;
                        // Requests seen during the sweep are merged into it
                        w_clear_pending_n = 1'b0;
                    end else begin
                        w_cy_n = r_cy + 1'b1;
                    end
                end else begin
                    w_cx_n = r_cx + 1'b1;
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state         <= ST_IDLE;
            r_rr_ptr        <= '0;
            r_idx           <= '0;
            r_clear_pending <= 1'b1;
            r_gnt           <= '0;
            r_cx            <= '0;
            r_cy            <= '0;
            r_x             <= '0;
            r_y             <= '0;
            r_col           <= '0;
            r_plot          <= 1'b0;
            r_busy          <= 1'b0;
        end else begin
            r_state         <= w_state_n;
            r_rr_ptr        <= w_rr_ptr_n;
            r_idx           <= w_idx_n;
            r_clear_pending <= w_clear_pending_n;
            r_gnt           <= w_gnt_n;
            r_cx            <= w_cx_n;
            r_cy            <= w_cy_n;
            r_x             <= w_x_n;
            r_y             <= w_y_n;
            r_col           <= w_col_n;
            r_plot          <= w_plot_n;
            r_busy          <= w_busy_n;
        end
    end

    assign o_gnt        = r_gnt;
    assign o_clear_busy = r_busy;
    assign o_vga_x      = r_x;
    assign o_vga_y      = r_y;
    assign o_vga_colour = r_col;
    assign o_vga_plot   = r_plot;

endmodule

`default_nettype wire

// File: tb/tb_vga_write_arbiter.sv
// ============================================================================
//  Module      : tb_vga_write_arbiter
//  Description : Self-checking bench for vga_write_arbiter: reset state,
//                power-up clear sweep, table-driven grant/forwarding vectors,
//                round-robin rotation, clear during a burst, reset mid-clear
//                and (with ARB_TIMEOUT_EN) the grant watchdog.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_vga_write_arbiter;
    import vga_arb_pkg::*;

    localparam int N = 3;
    localparam int W = 160;
    localparam int H = 120;

    localparam logic [23:0] NX = {8'hA2, 8'hA1, 8'hA0};
    localparam logic [20:0] NY = {7'h52, 7'h51, 7'h50};
    localparam logic [8:0]  NC = {3'd6, 3'd6, 3'd6};

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req, plot_in, last_in;
    logic [23:0]   x_in;
    logic [20:0]   y_in;
    logic [8:0]    col_in;
    logic          clear_req;
    logic [N-1:0]  gnt;
    logic          busy;
    logic [7:0]    vx;
    logic [6:0]    vy;
    logic [2:0]    vc;
    logic          vplot;
`ifdef ARB_TIMEOUT_EN
    logic          terr;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    vga_write_arbiter #(
        .N_REQ     (N),
        .SCREEN_W  (W),
        .SCREEN_H  (H),
        .MAX_BURST (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_req        (req),
        .i_plot_in    (plot_in),
        .i_last       (last_in),
        .i_x_in       (x_in),
        .i_y_in       (y_in),
        .i_colour_in  (col_in),
        .i_clear_req  (clear_req),
        .o_gnt        (gnt),
        .o_clear_busy (busy),
        .o_vga_x      (vx),
        .o_vga_y      (vy),
        .o_vga_colour (vc),
        .o_vga_plot   (vplot)
`ifdef ARB_TIMEOUT_EN
        ,
        .o_timeout_err(terr)
`endif
    );

    typedef struct {
        logic [2:0]  req, plot, last;
        logic [23:0] x;
        logic [20:0] y;
        logic [8:0]  c;
        logic [2:0]  e_gnt;
        logic        e_plot;
        logic [7:0]  e_x;
        logic [6:0]  e_y;
        logic [2:0]  e_c;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Follows a clear sweep pixel by pixel. Optionally pulses clear_req at
    // sweep index pulse_at, or returns at the negedge showing pixel abort_at.
    task automatic sweep_check(input string tag, input int abort_at, input int pulse_at);
        int w, bad;
        logic [7:0] lx;
        logic [6:0] ly;
        w = 0; bad = 0; lx = '0; ly = '0;
        while (!vplot && w < 8) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_start"}, 32'(vplot), 32'd1);
        if (!vplot) return;
        check({tag, "_first_xy"}, {vx, 1'b0, vy}, {8'd0, 1'b0, 7'd0});
        for (int i = 0; i < W*H; i++) begin
            if (vplot !== 1'b1 || busy !== 1'b1 || vc !== 3'd0 || gnt !== 3'b000 ||
                vx !== 8'(i % W) || vy !== 7'(i / W))
                bad++;
            if (i == abort_at) begin
                check({tag, "_pixels"}, 32'(bad), 32'd0);
                return;
            end
            if (i == W*H - 1) begin
                lx = vx;
                ly = vy;
            end
            clear_req = (i == pulse_at);
            @(negedge clk);
        end
        clear_req = 1'b0;
        check({tag, "_pixels"}, 32'(bad), 32'd0);
        check({tag, "_last_xy"}, {lx, 1'b0, ly}, {8'd159, 1'b0, 7'd119});
        check({tag, "_end_plot_busy"}, {vplot, busy}, 2'b00);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] g, prev_g, exp_g, pend_g;
        logic [7:0] px;
        logic [6:0] py;
        logic [2:0] pc;
        int beat[3];
        int blen, gap, bursts;

        tbl[0] = '{3'b010, 3'b000, 3'b000, NX, NY, NC, 3'b010, 1'b0, 8'h00, 7'h00, 3'd0};
        tbl[1] = '{3'b010, 3'b111, 3'b101, {8'hA2, 8'h0A, 8'hA0}, {7'h52, 7'd20, 7'h50},
                   {3'd6, 3'd5, 3'd6}, 3'b010, 1'b1, 8'h0A, 7'd20, 3'd5};
        tbl[2] = '{3'b111, 3'b101, 3'b000, {8'hA2, 8'h0B, 8'hA0}, NY, NC,
                   3'b010, 1'b0, 8'h00, 7'h00, 3'd0};
        tbl[3] = '{3'b111, 3'b010, 3'b000, {8'hA2, 8'h0C, 8'hA0}, {7'h52, 7'd21, 7'h50},
                   {3'd6, 3'd3, 3'd6}, 3'b010, 1'b1, 8'h0C, 7'd21, 3'd3};
        tbl[4] = '{3'b111, 3'b010, 3'b010, {8'hA2, 8'h0D, 8'hA0}, {7'h52, 7'd22, 7'h50},
                   {3'd6, 3'd7, 3'd6}, 3'b000, 1'b1, 8'h0D, 7'd22, 3'd7};
        tbl[5] = '{3'b111, 3'b111, 3'b111, NX, NY, NC, 3'b100, 1'b0, 8'h00, 7'h00, 3'd0};
        tbl[6] = '{3'b111, 3'b100, 3'b100, {8'h32, 8'hA1, 8'hA0}, {7'h3C, 7'h51, 7'h50},
                   {3'd1, 3'd6, 3'd6}, 3'b000, 1'b1, 8'h32, 7'h3C, 3'd1};
        tbl[7] = '{3'b101, 3'b000, 3'b000, NX, NY, NC, 3'b001, 1'b0, 8'h00, 7'h00, 3'd0};
        tbl[8] = '{3'b100, 3'b001, 3'b000, {8'hA2, 8'hA1, 8'h4D}, {7'h52, 7'h51, 7'h11},
                   {3'd6, 3'd6, 3'd2}, 3'b000, 1'b1, 8'h4D, 7'h11, 3'd2};
        tbl[9] = '{3'b000, 3'b000, 3'b000, NX, NY, NC, 3'b000, 1'b0, 8'h00, 7'h00, 3'd0};

        // ---------------- reset state ----------------
        reset = 1'b0; req = '0; plot_in = '0; last_in = '0;
        x_in = '0; y_in = '0; col_in = '0; clear_req = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_plot_busy", {vplot, busy}, 2'b00);
        check("rst_xyc", {vx, vy, vc}, 18'd0);

        // ---------------- power-up clear ----------------
        reset = 1'b1;
        sweep_check("boot", -1, -1);

        // ---------------- table-driven grant/forwarding ----------------
        for (int i = 0; i < 10; i++) begin
            req = tbl[i].req; plot_in = tbl[i].plot; last_in = tbl[i].last;
            x_in = tbl[i].x; y_in = tbl[i].y; col_in = tbl[i].c;
            @(negedge clk);
            check($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(tbl[i].e_gnt));
            check($sformatf("vec%0d_plot", i), 32'(vplot), 32'(tbl[i].e_plot));
            if (tbl[i].e_plot)
                check($sformatf("vec%0d_xyc", i), {vx, vy, vc},
                      {tbl[i].e_x, tbl[i].e_y, tbl[i].e_c});
        end

        // ---------------- round-robin rotation, 10-beat bursts ----------------
        // rr_ptr is 1 after the table, so the rotation starts at client 1.
        for (int i = 0; i < 3; i++) beat[i] = 0;
        exp_g = 3'b010; prev_g = '0; pend_g = '0;
        px = '0; py = '0; pc = '0;
        blen = 0; gap = 0; bursts = 0;
        req = 3'b111; plot_in = '0; last_in = '0;
        @(negedge clk);
        for (int cyc = 0; cyc < 120; cyc++) begin
            g = gnt;
            if (pend_g != 3'b000) begin
                check("rot_pix_plot", 32'(vplot), 32'd1);
                check("rot_pix_xyc", {vx, vy, vc}, {px, py, pc});
            end else begin
                check("rot_gap_noplot", 32'(vplot), 32'd0);
            end
            if (g != 3'b000 && prev_g == 3'b000) begin
                check("rot_order", 32'(g), 32'(exp_g));
                if (bursts > 0) check("rot_gap_len", 32'(gap), 32'd1);
                exp_g = {exp_g[1:0], exp_g[2]};
                blen = 0;
            end
            if (g == 3'b000 && prev_g != 3'b000) begin
                bursts++;
                check("rot_burst_len", 32'(blen), 32'd10);
                gap = 0;
            end
            if (g != 3'b000) blen++;
            else             gap++;
            prev_g = g;
            if (bursts == 6) break;
            pend_g = g;
            for (int i = 0; i < 3; i++) begin
                if (g[i]) begin
                    x_in[i*8 +: 8]   = 8'(i*16 + beat[i]);
                    y_in[i*7 +: 7]   = 7'(i + 1);
                    col_in[i*3 +: 3] = 3'(i + 1);
                    plot_in[i] = 1'b1;
                    last_in[i] = (beat[i] == 9);
                    px = 8'(i*16 + beat[i]); py = 7'(i + 1); pc = 3'(i + 1);
                    beat[i] = (beat[i] == 9) ? 0 : beat[i] + 1;
                end else begin
                    x_in[i*8 +: 8]   = 8'hF0 | 8'(i);
                    y_in[i*7 +: 7]   = 7'h7F;
                    col_in[i*3 +: 3] = 3'd7;
                    plot_in[i] = 1'b1;
                    last_in[i] = 1'b1;
                end
            end
            @(negedge clk);
        end
        check("rot_bursts_done", 32'(bursts), 32'd6);
        req = '0; plot_in = '0; last_in = '0;

        // ---------------- clear_req during client 2's burst ----------------
        x_in = NX; y_in = NY; col_in = NC;
        req = 3'b100;
        @(negedge clk);
        check("clr_gnt2", 32'(gnt), 32'b100);
        for (int b = 0; b < 4; b++) begin
            plot_in = 3'b100;
            last_in = (b == 3) ? 3'b100 : 3'b000;
            x_in[23:16] = 8'(b + 1);
            clear_req = (b == 1);
            @(negedge clk);
            clear_req = 1'b0;
            if (b < 3) check($sformatf("clr_burst_hold%0d", b), 32'(gnt), 32'b100);
        end
        check("clr_burst_end_gnt", 32'(gnt), 32'd0);
        check("clr_final_pixel", {vplot, busy, vx}, {1'b1, 1'b0, 8'd4});
        req = 3'b111; plot_in = '0; last_in = '0;
        @(negedge clk);
        check("clr_gap_gnt", 32'(gnt), 32'd0);
        // Second clear_req mid-sweep must merge into the running sweep
        sweep_check("clr", -1, 100);
        check("clr_then_gnt0", 32'(gnt), 32'b001);
        req = '0;
        @(negedge clk);
        check("clr_gnt0_release", 32'(gnt), 32'd0);

        // ---------------- reset at clear pixel 5000 ----------------
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        sweep_check("pre_rst", 5000, -1);
        reset = 1'b0;
        @(negedge clk);
        check("midclr_rst_plot_busy", {vplot, busy}, 2'b00);
        check("midclr_rst_gnt", 32'(gnt), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        sweep_check("post_rst", -1, -1);

`ifdef ARB_TIMEOUT_EN
        // ---------------- grant watchdog ----------------
        begin
            int gl, tp;
            logic [2:0] second;
            gl = 0; tp = 0; second = '0;
            req = 3'b011; plot_in = 3'b011; last_in = '0;
            for (int c = 0; c < 24; c++) begin
                @(negedge clk);
                if (gnt == 3'b001) gl++;
                if (terr) tp++;
                if (gnt != 3'b000 && gnt != 3'b001 && second == 3'b000) second = gnt;
            end
            check("to_grant_len", 32'(gl), 32'd16);
            check("to_err_pulses", 32'(tp), 32'd1);
            check("to_next_gnt", 32'(second), 32'b010);
            req = '0; plot_in = '0;
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
